ofm_reader: RTL and testbench

OFM_READER -- requirements
Module: ofm_reader

---
 rtl/ofm_reader_if.sv | 30 +++
 rtl/ofm_reader.sv | 142 ++++++++++++++
 tb/tb_ofm_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ofm_reader_if.sv
// Bundles the OFM DPRAM read port and the streamed output port of ofm_reader.
// master = the reader; slave = memory plus downstream consumer.
interface ofm_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 17
);
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr;
  logic [2*DATA_WIDTH-1:0] mem_rd_data;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_eol;
  logic                    out_eoc;
  logic                    out_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_data, out_valid, out_eol, out_eoc, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_data, out_valid, out_eol, out_eoc, out_last,
    output out_ready
  );
endinterface

// File: rtl/ofm_reader.sv
// Streams a whole OFM out of the DPRAM (channel-major, row-major) through a
// 2-entry FIFO, tagging row/channel/final boundaries and summing transfers.
module ofm_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OFM_SIZE   = 13,
  parameter int unsigned NO_FILTER  = 512,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  ofm_reader_if.master  bus,
  output logic          busy,
  output logic          done,
  output logic [31:0]   checksum
);
  localparam int unsigned WW  = 2*DATA_WIDTH;
  localparam int unsigned PIX = OFM_SIZE*OFM_SIZE;
  localparam int unsigned N   = PIX*NO_FILTER;
  localparam int unsigned CW  = $clog2(OFM_SIZE+1);
  localparam int unsigned PW  = $clog2(PIX+1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] col_cnt;
  logic [PW-1:0] pix_cnt;
  logic          pend_vld, pend_eol, pend_eoc, pend_last;
  logic [WW-1:0] slot_data;
  logic          slot_vld, slot_eol, slot_eoc, slot_last;
  logic          pop, last_xfer, rd_go, rd_eol, rd_eoc, rd_last;
  logic [1:0]    credit;

  // mem_rd_en is derived from registered state and this cycle's pop, so the
  // slot freed by a pop is reused at once; 2 credits still give 1 beat/cycle.
  always_comb begin
    pop       = bus.out_valid & bus.out_ready;
    last_xfer = pop & bus.out_last;
    credit    = 2'(bus.out_valid) + 2'(slot_vld) + 2'(pend_vld) - 2'(pop);
    rd_eol    = (col_cnt == CW'(OFM_SIZE-1));
    rd_eoc    = (pix_cnt == PW'(PIX-1));
    rd_last   = (bus.mem_rd_addr == ADDR_WIDTH'(N-1));
    rd_go     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        rd_go = (credit < 2'd2);
        if (rd_go && rd_last) state_nxt = FLUSH;
      end
      FLUSH: if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.mem_rd_en = rd_go;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_rd_addr <= '0;
      col_cnt         <= '0;
      pix_cnt         <= '0;
      pend_vld        <= 1'b0;
      pend_eol        <= 1'b0;
      pend_eoc        <= 1'b0;
      pend_last       <= 1'b0;
      slot_data       <= '0;
      slot_vld        <= 1'b0;
      slot_eol        <= 1'b0;
      slot_eoc        <= 1'b0;
      slot_last       <= 1'b0;
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_eol     <= 1'b0;
      bus.out_eoc     <= 1'b0;
      bus.out_last    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      checksum        <= '0;
    end else begin
      done      <= 1'b0;
      pend_vld  <= rd_go;
      pend_eol  <= rd_eol;
      pend_eoc  <= rd_eoc;
      pend_last <= rd_last;

      if (state == IDLE && start) begin
        bus.mem_rd_addr <= '0;
        col_cnt         <= '0;
        pix_cnt         <= '0;
        checksum        <= '0;
        busy            <= 1'b1;
      end

      if (rd_go && !rd_last) begin
        bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_WIDTH'(1);
        col_cnt         <= rd_eol ? '0 : col_cnt + CW'(1);
        pix_cnt         <= rd_eoc ? '0 : pix_cnt + PW'(1);
      end

      if (pop) checksum <= checksum + 32'($signed(bus.out_data));

      if (last_xfer) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      // Head register is the FIFO output; the second slot only fills while
      // the head is stalled.
      if (!bus.out_valid || bus.out_ready) begin
        if (slot_vld) begin
          bus.out_data  <= slot_data;
          bus.out_valid <= 1'b1;
          bus.out_eol   <= slot_eol;
          bus.out_eoc   <= slot_eoc;
          bus.out_last  <= slot_last;
          slot_vld      <= pend_vld;
          slot_data     <= bus.mem_rd_data;
          slot_eol      <= pend_eol;
          slot_eoc      <= pend_eoc;
          slot_last     <= pend_last;
        end else begin
          bus.out_valid <= pend_vld;
          bus.out_data  <= pend_vld ? bus.mem_rd_data : '0;
          bus.out_eol   <= pend_vld & pend_eol;
          bus.out_eoc   <= pend_vld & pend_eoc;
          bus.out_last  <= pend_vld & pend_last;
        end
      end else if (pend_vld) begin
        slot_vld  <= 1'b1;
        slot_data <= bus.mem_rd_data;
        slot_eol  <= pend_eol;
        slot_eoc  <= pend_eoc;
        slot_last <= pend_last;
      end
    end
  end
endmodule

// File: tb/tb_ofm_reader.sv
// Directed bench for ofm_reader with a 3x3x2 OFM and a 1-cycle-latency memory.
module tb_ofm_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned OS = 3;
  localparam int unsigned NF = 2;
  localparam int unsigned AW = 17;
  localparam int          N  = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [31:0] checksum;

  ofm_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ofm_reader #(.DATA_WIDTH(DW), .OFM_SIZE(OS), .NO_FILTER(NF), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  logic [15:0] tb_mem [N];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= tb_mem[int'(bus.mem_rd_addr) % N];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int ready_mode = 0;
  int stall_left = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = !bus.out_ready;
        default: begin
          bus.out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
    end
  end

  int exp_idx, beat_cnt, rd_exp, rd_cnt, done_cnt, first_cyc, last_cyc;
  int cyc = 0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_word;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.mem_rd_en) begin
        check("rd_addr", 32'(bus.mem_rd_addr), 32'(rd_exp));
        rd_exp++;
        rd_cnt++;
      end
      if (prev_stall)
        check("stall_hold", {12'd0, bus.out_valid, bus.out_eol, bus.out_eoc, bus.out_last, bus.out_data},
              {12'd0, prev_word});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_idx < N) begin
          check("data", 32'(bus.out_data), 32'(tb_mem[exp_idx]));
          check("eol",  32'(bus.out_eol),  32'((exp_idx + 1) % OS == 0));
          check("eoc",  32'(bus.out_eoc),  32'((exp_idx + 1) % (OS*OS) == 0));
          check("last", 32'(bus.out_last), 32'(exp_idx == N - 1));
        end
        if (beat_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        exp_idx++;
        beat_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_valid, bus.out_eol, bus.out_eoc, bus.out_last, bus.out_data};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm();
    exp_idx = 0; beat_cnt = 0; rd_exp = 0; rd_cnt = 0; done_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 100 && beat_cnt < n; i++) tick();
    check(tag, 32'(beat_cnt >= n), 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] exp_sum);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_checksum"}, checksum, exp_sum);
    check({tag, "_beats"}, 32'(beat_cnt), 32'(N));
    check({tag, "_reads"}, 32'(rd_cnt), 32'(N));
    tick();
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_checksum_stable"}, checksum, exp_sum);
    tick(); tick();
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},    32'(bus.mem_rd_en),   32'd0);
    check({tag, "_rd_addr"},  32'(bus.mem_rd_addr), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data),    32'd0);
    check({tag, "_valid"},    32'(bus.out_valid),   32'd0);
    check({tag, "_flags"},    32'({bus.out_eol, bus.out_eoc, bus.out_last}), 32'd0);
    check({tag, "_busy"},     32'(busy),            32'd0);
    check({tag, "_done"},     32'(done),            32'd0);
    check({tag, "_checksum"}, checksum,             32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) tb_mem[i] = 16'(i);
    arm();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Free-flowing readout with first-read and first-beat latency checks.
    arm();
    pulse_start();
    check("t1_first_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("t1_first_addr",  32'(bus.mem_rd_addr), 32'd0);
    check("t1_busy",        32'(busy), 32'd1);
    tick();
    check("t1_valid_c2", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid_c3", 32'(bus.out_valid), 32'd1);
    check("t1_data_c3",  32'(bus.out_data), 32'd0);
    run_and_check("t1", 32'd153);
    check("t1_gapless", 32'(last_cyc - first_cyc), 32'(N - 1));

    // Alternating ready.
    ready_mode = 1;
    arm();
    pulse_start();
    run_and_check("t2", 32'd153);
    ready_mode = 0;
    tick();

    // Long initial stall.
    ready_mode = 2;
    stall_left = 12;
    arm();
    pulse_start();
    repeat (8) tick();
    check("t3_reads_le2", 32'(rd_cnt <= 2), 32'd1);
    check("t3_valid",     32'(bus.out_valid), 32'd1);
    check("t3_data0",     32'(bus.out_data), 32'd0);
    run_and_check("t3", 32'd153);
    ready_mode = 0;
    tick();

    // Negative words: 18 * -1.
    for (int i = 0; i < N; i++) tb_mem[i] = 16'hFFFF;
    arm();
    pulse_start();
    run_and_check("t4", 32'hFFFF_FFEE);
    for (int i = 0; i < N; i++) tb_mem[i] = 16'(i);

    // Reset mid-readout, then a clean restart.
    arm();
    pulse_start();
    wait_beats("t5_reach8", 8);
    rst = 1'b1;
    #1;
    check_all_zero("t5_midrst");
    tick();
    rst = 1'b0;
    tick();
    arm();
    pulse_start();
    run_and_check("t5", 32'd153);

    // Start re-pulsed mid-stream is ignored.
    arm();
    pulse_start();
    wait_beats("t6_reach5", 5);
    pulse_start();
    run_and_check("t6", 32'd153);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
